univ_shift_reg: RTL

Parametrised universal shift register: the registered, resettable, mode-controlled successor to our latch-based 8-bit serial shifter. It holds a WIDTH-bit word and supports hold, right shift, left shift and parallel load. It counts shifts since the last load and pulses `done` once a full word has been shifted. It sits between the serial link front-ends and the parallel datapath as a serialiser/deserialiser.

---
 rtl/univ_shift_reg_pkg.sv | 17 +
 rtl/sr_shift_counter.sv | 63 ++++++
 rtl/univ_shift_reg.sv | 77 +++++++
 3 files changed

// File: rtl/univ_shift_reg_pkg.sv
// Shared types for the universal shift register: the per-cycle operation encoding.
// Imported by univ_shift_reg and sr_shift_counter.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } shift_mode_e;

    // Operations that advance the shift counter.
    function automatic logic is_shift(input shift_mode_e m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/sr_shift_counter.sv
// Saturating shift counter: counts shifts since the last clear, stops at WIDTH
// and emits a single-cycle done pulse on the shift that reaches WIDTH.
module sr_shift_counter
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);

    localparam logic [0:0] ST_COUNTING = 1'b0;
    localparam logic [0:0] ST_FULL     = 1'b1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (clr_i) begin
            state_d = ST_COUNTING;
            cnt_d   = '0;
        end else if (inc_i) begin
            case (state_q)
                ST_COUNTING: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_FULL;
                        done_d  = 1'b1;
                    end
                end
                // FULL absorbs further shifts: count pinned at WIDTH, no new pulse.
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_COUNTING;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = done_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold / shift right / shift left / parallel load) with
// shift counter. Define UNIV_SHIFT_REG_ROTATE_EN to add the rot input for rotation.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    input  logic [WIDTH-1:0] par_in,
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             done
);

    shift_mode_e      mode_e;
    logic [WIDTH-1:0] q_q, q_d;
    logic             fill_r, fill_l;

    assign mode_e = shift_mode_e'(mode);

    // Bit entering the vacated end: serial input, or the opposite end when rotating.
`ifdef UNIV_SHIFT_REG_ROTATE_EN
    assign fill_r = rot ? q_q[0]       : ser_in_r;
    assign fill_l = rot ? q_q[WIDTH-1] : ser_in_l;
`else
    assign fill_r = ser_in_r;
    assign fill_l = ser_in_l;
`endif

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode_e)
                MODE_SHR:  q_d = {fill_r, q_q[WIDTH-1:1]};
                MODE_SHL:  q_d = {q_q[WIDTH-2:0], fill_l};
                MODE_LOAD: q_d = par_in;
                default:   q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    sr_shift_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (en && (mode_e == MODE_LOAD)),
        .inc_i  (en && is_shift(mode_e)),
        .cnt_o  (shift_cnt),
        .done_o (done)
    );

    assign par_out   = q_q;
    assign ser_out_r = q_q[0];
    assign ser_out_l = q_q[WIDTH-1];

endmodule
